// File: rtl/pid_seq_pkg.sv
// Shared types and default tuning for the pid_seq sequencer.
// The watchdog is a build option controlled by PID_SEQ_WDOG_EN.
package pid_seq_pkg;

  typedef enum logic [2:0] {
    ST_OFF        = 3'd0,
    ST_WAIT_RIDER = 3'd1,
    ST_SOFT       = 3'd2,
    ST_BAL        = 3'd3,
    ST_FAULT      = 3'd4
  } pid_state_e;

  localparam logic [15:0] TILT_LIM_DEF = 16'h1800;
  localparam int unsigned TILT_CNT_DEF = 8;
  localparam int unsigned RIDER_DB_DEF = 4;
  localparam int unsigned VLD_TO_DEF   = 4000;

  // ss_tmr value at which the PID has finished ramping up
  localparam logic [7:0] SS_DONE = 8'hFF;

endpackage

// File: rtl/pid_seq_smpl_db_cnt.sv
// Consecutive-sample debounce counter: hit rises on the N-th qualifying strobe
// in a row (same cycle) and is then held until clr.
module smpl_db_cnt
  import pid_seq_pkg::*;
#(
  parameter int unsigned N = RIDER_DB_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic smpl,
  input  logic cond,
  output logic hit
);

  localparam int unsigned W = (N > 1) ? $clog2(N) : 1;

  logic [W-1:0] cnt_q, cnt_d;
  logic         hit_q, hit_d;
  logic         last;

  // Combinational term lets the sequencer react on the qualifying strobe itself
  assign last = smpl && cond && (cnt_q == W'(N - 1));
  assign hit  = hit_q || last;

  always_comb begin
    cnt_d = cnt_q;
    hit_d = hit_q;
    if (clr) begin
      cnt_d = '0;
      hit_d = 1'b0;
    end else if (smpl) begin
      if (!cond)
        cnt_d = '0;
      else if (last)
        hit_d = 1'b1;
      else if (!hit_q)
        cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      hit_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      hit_q <= hit_d;
    end
  end

endmodule

// File: rtl/pid_seq.sv
// pid_seq: power / rider / soft-start / balance sequencer driving the PID controls.
// Define PID_SEQ_WDOG_EN to build the ptch_vld-loss watchdog fault.
module pid_seq
  import pid_seq_pkg::*;
#(
  parameter int unsigned       DATA_W   = 16,
  parameter logic [DATA_W-1:0] TILT_LIM = DATA_W'(TILT_LIM_DEF),
  parameter int unsigned       TILT_CNT = TILT_CNT_DEF,
  parameter int unsigned       RIDER_DB = RIDER_DB_DEF,
  parameter int unsigned       VLD_TO   = VLD_TO_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pwr_on,
  input  logic                     rider_pres,
  input  logic                     ptch_vld,
  input  logic signed [DATA_W-1:0] ptch,
  input  logic [7:0]               ss_tmr,
  output logic                     vld,
  output logic                     pwr_up,
  output logic                     rider_off,
  output logic                     mtr_en,
  output logic                     fault,
  output logic [2:0]               state
);

  function automatic logic [DATA_W-1:0] sat_abs(input logic signed [DATA_W-1:0] x);
    logic signed [DATA_W-1:0] neg;
    neg = -x;
    if (!x[DATA_W-1])
      return x;
    if (neg[DATA_W-1])
      return {1'b0, {(DATA_W-1){1'b1}}};
    return neg;
  endfunction

  pid_state_e state_q, state_d;
  logic       vld_q, pwr_up_q, rider_off_q, mtr_en_q, fault_q;
  logic       clr, tilt_cond;
  logic       on_hit, off_hit, tilt_hit, wd_exp;

  assign tilt_cond = (sat_abs(ptch) >= TILT_LIM);
  assign clr       = (state_d != state_q);

  smpl_db_cnt #(.N(RIDER_DB)) u_rider_on (
    .clk(clk), .rst(rst), .clr(clr), .smpl(ptch_vld),
    .cond(rider_pres && !tilt_cond), .hit(on_hit)
  );

  smpl_db_cnt #(.N(RIDER_DB)) u_rider_off (
    .clk(clk), .rst(rst), .clr(clr), .smpl(ptch_vld),
    .cond(!rider_pres), .hit(off_hit)
  );

  smpl_db_cnt #(.N(TILT_CNT)) u_tilt (
    .clk(clk), .rst(rst), .clr(clr), .smpl(ptch_vld),
    .cond(tilt_cond), .hit(tilt_hit)
  );

`ifdef PID_SEQ_WDOG_EN
  localparam int unsigned WD_W = $clog2(VLD_TO + 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            bal_act;

  assign bal_act = (state_q == ST_SOFT) || (state_q == ST_BAL);
  assign wd_exp  = bal_act && !ptch_vld && (wd_q == WD_W'(VLD_TO - 1));

  always_comb begin
    wd_d = '0;
    if (bal_act && !ptch_vld && !clr)
      wd_d = wd_q + WD_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wd_q <= '0;
    else
      wd_q <= wd_d;
  end
`else
  assign wd_exp = 1'b0 && (VLD_TO != 0);
`endif

  // Priority: power off, then fault, then rider leaving, then forward progress
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OFF:
        if (pwr_on) state_d = ST_WAIT_RIDER;
      ST_WAIT_RIDER:
        if (!pwr_on)     state_d = ST_OFF;
        else if (on_hit) state_d = ST_SOFT;
      ST_SOFT, ST_BAL:
        if (!pwr_on)                 state_d = ST_OFF;
        else if (tilt_hit || wd_exp) state_d = ST_FAULT;
        else if (off_hit)            state_d = ST_WAIT_RIDER;
        else if (state_q == ST_SOFT && ss_tmr == SS_DONE)
          state_d = ST_BAL;
      ST_FAULT:
        if (!pwr_on) state_d = ST_OFF;
      default:
        state_d = ST_OFF;
    endcase
  end

  // Outputs are decoded from the next state so they are registered alongside it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_OFF;
      vld_q       <= 1'b0;
      pwr_up_q    <= 1'b0;
      rider_off_q <= 1'b1;
      mtr_en_q    <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_q   <= ptch_vld && (state_d != ST_OFF) && (state_d != ST_FAULT);
      case (state_d)
        ST_WAIT_RIDER: begin
          pwr_up_q <= 1'b1; rider_off_q <= 1'b1; mtr_en_q <= 1'b0; fault_q <= 1'b0;
        end
        ST_SOFT, ST_BAL: begin
          pwr_up_q <= 1'b1; rider_off_q <= 1'b0; mtr_en_q <= 1'b1; fault_q <= 1'b0;
        end
        ST_FAULT: begin
          pwr_up_q <= 1'b0; rider_off_q <= 1'b1; mtr_en_q <= 1'b0; fault_q <= 1'b1;
        end
        default: begin
          pwr_up_q <= 1'b0; rider_off_q <= 1'b1; mtr_en_q <= 1'b0; fault_q <= 1'b0;
        end
      endcase
    end
  end

  assign vld       = vld_q;
  assign pwr_up    = pwr_up_q;
  assign rider_off = rider_off_q;
  assign mtr_en    = mtr_en_q;
  assign fault     = fault_q;
  assign state     = state_q;

endmodule

// File: doc/pid_seq.md
# pid_seq

Sequencer in front of the PID block: decides when the controller is powered, when its integrator may run and when motors may be driven. Consumes inertial sample strobes, rider-presence and pitch; drives the PID's `vld`, `pwr_up` and `rider_off` inputs plus the motor enable. It tracks soft-start via the PID's `ss_tmr` and traps tilt and sensor-loss faults.

## Interface
- `TILT_LIM`, default 16'h1800: unsigned pitch-magnitude fault threshold.
- `TILT_CNT`, default 8: consecutive over-limit samples before a tilt fault.
- `RIDER_DB`, default 4: consecutive samples needed to accept rider on or rider off.
- `VLD_TO`, default 4000: clocks without `ptch_vld` before a watchdog fault.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `pwr_on` in 1: synchronized power-button level.
- `rider_pres` in 1: thresholded load-cell rider-present flag.
- `ptch_vld` in 1: one-cycle strobe from the inertial interface.
- `ptch` in 16: signed pitch, stable from strobe until the next strobe.
- `ss_tmr` in 8: PID soft-start timer.
- `vld` out 1: sample strobe to the PID.
- `pwr_up` out 1: PID soft-start enable.
- `rider_off` out 1: PID integrator clear/hold.
- `mtr_en` out 1: motor drive enable.
- `fault` out 1: sticky fault flag.
- `state` out 3: debug view of the state register.

## Operation
- States (encoding): OFF=0, WAIT_RIDER=1, SOFT=2, BAL=3, FAULT=4.
- Output decode comes from the state register only, with no input-to-output combinational paths:
  - OFF: `pwr_up`=0, `rider_off`=1, `mtr_en`=0, `fault`=0.
  - WAIT_RIDER: `pwr_up`=1, `rider_off`=1, `mtr_en`=0.
  - SOFT and BAL: `pwr_up`=1, `rider_off`=0, `mtr_en`=1.
  - FAULT: `pwr_up`=0, `rider_off`=1, `mtr_en`=0, `fault`=1.
- Transitions:
  - OFF→WAIT_RIDER when `pwr_on`=1.
  - WAIT_RIDER→SOFT after RIDER_DB consecutive samples with `rider_pres`=1 and |ptch|<TILT_LIM. A failing sample zeroes the count.
  - SOFT→BAL on the first cycle `ss_tmr`==8'hFF.
  - SOFT/BAL→WAIT_RIDER after RIDER_DB consecutive samples with `rider_pres`=0.
  - SOFT/BAL→FAULT after TILT_CNT consecutive samples with |ptch|≥TILT_LIM, or on watchdog expiry.
  - FAULT→OFF only when `pwr_on`=0.
  - Any state→OFF when `pwr_on`=0.
- Priority: `pwr_on`=0 > fault > rider-off > forward progress.
- |ptch|: two's-complement magnitude; 16'h8000 saturates to 16'h7FFF.
- Counters count sampled events only, i.e. cycles with `ptch_vld`=1. Every counter clears on any state change.
- Watchdog (SOFT/BAL only): counts clocks, clears on every `ptch_vld`; reaching VLD_TO → FAULT.
- `vld` = `ptch_vld` registered one cycle, forced to 0 in OFF and FAULT.

## Timing
- Reset: state OFF, `vld`=0, `pwr_up`=0, `rider_off`=1, `mtr_en`=0, `fault`=0, all counters 0.
- A qualifying sample at cycle N registers the new state at N+1; outputs change at N+1.
- `vld` latency is 1 clock; `ptch` stays valid to the PID because the source holds it.
- Reset asserted mid-operation returns to OFF immediately (asynchronous) and drops `mtr_en` in the same cycle.
- A tilt sample and a rider-off sample on the same strobe: FAULT wins.
- `ss_tmr`==8'hFF on the same strobe as the final rider-off sample: WAIT_RIDER wins.

## Configuration
- `PID_SEQ_WDOG_EN` defined: the watchdog counter and its FAULT transition are built.
- `PID_SEQ_WDOG_EN` undefined: no watchdog logic; loss of `ptch_vld` simply stalls the counters.

## Structure
- `pid_seq_pkg` holds:
  - the state enum typedef;
  - default values of TILT_LIM, TILT_CNT, RIDER_DB and VLD_TO;
  - the 8'hFF soft-start-done constant.
- Sub-module `smpl_db_cnt`: a parameterized consecutive-sample counter with inputs `clk`, `rst`, `clr`, `smpl`, `cond` and output `hit`.
  - Instantiated for rider-on, rider-off and tilt.
  - `hit` is held until `clr`.

## Test plan
- Reset then `pwr_on`=1 → `state`=1, `pwr_up`=1, `rider_off`=1 on the next clock.
- `rider_pres`=1 with 4 strobes, `ptch`=16'h0100 → SOFT after the 4th strobe (`mtr_en`=1). Drive `ss_tmr`=8'hFF → BAL.
- In BAL, `ptch`=16'hE000 for 8 strobes → FAULT, `fault`=1, `mtr_en`=0. `pwr_on`=0 → OFF, `fault`=0.
- In BAL, `rider_pres`=0 for 3 strobes then 1 → stays BAL. Then `rider_pres`=0 for 4 strobes → WAIT_RIDER, `rider_off`=1.
- With `PID_SEQ_WDOG_EN`, stop strobes in BAL for 4000 clocks → FAULT. Without the macro → remains BAL.
- `ptch`=16'h8000 for 8 strobes → FAULT; `rst` pulse mid-SOFT → all outputs at reset values within the same cycle.
